// File: rtl/hart_slice_arbiter.sv
// hart_slice_arbiter: time-slices one shared MMU/interconnect port among
// N_HARTS cores. Round-robin over active harts, QUANTUM-cycle minimum slices,
// switch only at an owner-reported safe point, with a one-cycle drain state
// (SWITCH) between owners.
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   w_active         per-hart runnable
//   w_safe           per-hart safe-to-switch point
//   w_hold           global inhibit of SWITCH entry
//   w_shared_busy    shared port / TLB busy
//   w_hart_sel       current owner index (registered)
//   w_grant          one-hot owner, zero during SWITCH
//   w_core_busy      per-hart stall
//   w_switch         high during the SWITCH cycle
//   w_state          0=OWN 1=WAIT_SAFE 2=SWITCH
//   w_switch_count   completed switches, saturating
module hart_slice_arbiter #(
  parameter int unsigned N_HARTS = 2,
  parameter int unsigned QUANTUM = 64,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned SEL_W   = ($clog2(N_HARTS) > 0) ? $clog2(N_HARTS) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_HARTS-1:0] w_active,
  input  logic [N_HARTS-1:0] w_safe,
  input  logic               w_hold,
  input  logic               w_shared_busy,
  output logic [SEL_W-1:0]   w_hart_sel,
  output logic [N_HARTS-1:0] w_grant,
  output logic [N_HARTS-1:0] w_core_busy,
  output logic               w_switch,
  output logic [1:0]         w_state,
  output logic [CNT_W-1:0]   w_switch_count
);

  localparam int unsigned Q_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [Q_W-1:0] Q_RELOAD = Q_W'(QUANTUM - 1);

  typedef enum logic [1:0] {
    ST_OWN       = 2'd0,
    ST_WAIT_SAFE = 2'd1,
    ST_SWITCH    = 2'd2
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_next;
  logic [Q_W-1:0]     r_q;
  logic [CNT_W-1:0]   r_count;

  logic [2*N_HARTS-1:0] act_rot;
  logic                 has_cand;
  logic [SEL_W-1:0]     cand;

  // Rotate so bit k is hart (sel+k) mod N; lowest k>0 that is active wins.
  assign act_rot = {w_active, w_active} >> r_sel;

  always_comb begin
    has_cand = 1'b0;
    cand     = '0;
    for (int unsigned k = N_HARTS - 1; k >= 1; k--) begin
      if (act_rot[k]) begin
        has_cand = 1'b1;
        cand     = SEL_W'((32'(r_sel) + k) % N_HARTS);
      end
    end
  end

  // Ownership FSM with quantum counter and saturating switch counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_OWN;
      r_sel   <= '0;
      r_next  <= '0;
      r_q     <= Q_RELOAD;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_OWN: begin
          if (r_q != '0) r_q <= r_q - Q_W'(1);
          // An inactive owner is preempted without waiting out its slice.
          if (has_cand && ((r_q == '0) || !w_active[r_sel])) r_state <= ST_WAIT_SAFE;
        end
        ST_WAIT_SAFE: begin
          if (!has_cand) begin
            r_state <= ST_OWN;
          end else if (w_safe[r_sel] && !w_hold) begin
            r_next  <= cand;
            r_state <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          r_sel   <= r_next;
          r_q     <= Q_RELOAD;
          r_state <= ST_OWN;
          if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
        end
        default: r_state <= ST_OWN;
      endcase
    end
  end

  // Outputs decode straight from registers; only core_busy sees w_shared_busy.
  assign w_hart_sel     = r_sel;
  assign w_state        = r_state;
  assign w_switch       = (r_state == ST_SWITCH);
  assign w_switch_count = r_count;
  assign w_grant        = (r_state == ST_SWITCH) ? '0 : (N_HARTS'(1) << r_sel);
  assign w_core_busy    = ~w_grant | (w_grant & {N_HARTS{w_shared_busy}});

endmodule

// File: tb/tb_hart_slice_arbiter.sv
// Bench for hart_slice_arbiter: a 2-hart and a 3-hart (3-bit counter) instance
// checked every cycle against an integer-level model, plus literal pins.
module tb_hart_slice_arbiter;

  localparam int unsigned Q = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic       hold, sb;
  logic [1:0] act2, safe2;
  logic [2:0] act3, safe3;

  logic [0:0]  sel2;
  logic [1:0]  grant2, cbusy2, st2;
  logic        sw2;
  logic [15:0] cnt2;
  logic [1:0]  sel3;
  logic [2:0]  grant3, cbusy3;
  logic [1:0]  st3;
  logic        sw3;
  logic [2:0]  cnt3;

  hart_slice_arbiter #(.N_HARTS(2), .QUANTUM(Q), .CNT_W(16)) u2 (
    .CLK(CLK), .RST(RST), .w_active(act2), .w_safe(safe2), .w_hold(hold),
    .w_shared_busy(sb), .w_hart_sel(sel2), .w_grant(grant2), .w_core_busy(cbusy2),
    .w_switch(sw2), .w_state(st2), .w_switch_count(cnt2));

  hart_slice_arbiter #(.N_HARTS(3), .QUANTUM(Q), .CNT_W(3)) u3 (
    .CLK(CLK), .RST(RST), .w_active(act3), .w_safe(safe3), .w_hold(hold),
    .w_shared_busy(sb), .w_hart_sel(sel3), .w_grant(grant3), .w_core_busy(cbusy3),
    .w_switch(sw3), .w_state(st3), .w_switch_count(cnt3));

  // Model: owner, slice cycles left, phase (0 own, 1 waiting, 2 draining),
  // chosen successor, switch count.
  typedef struct {
    int sel;
    int q;
    int ph;
    int nxt;
    int cnt;
  } mdl_t;

  mdl_t m2, m3;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;

  function automatic mdl_t mstep(input mdl_t m, input int n, input int quantum,
                                 input int cmax, input bit rst,
                                 input int unsigned act, input int unsigned safe,
                                 input bit hld);
    mdl_t r = m;
    int cand = -1;
    if (rst) begin
      r.sel = 0; r.q = quantum - 1; r.ph = 0; r.nxt = 0; r.cnt = 0;
      return r;
    end
    for (int k = 1; k < n; k++) begin
      int g = (m.sel + k) % n;
      if (cand < 0 && ((act >> g) & 1) == 1) cand = g;
    end
    case (m.ph)
      0: begin
        if (m.q > 0) r.q = m.q - 1;
        if (cand >= 0 && (m.q == 0 || ((act >> m.sel) & 1) == 0)) r.ph = 1;
      end
      1: begin
        if (cand < 0) r.ph = 0;
        else if (((safe >> m.sel) & 1) == 1 && !hld) begin
          r.nxt = cand; r.ph = 2;
        end
      end
      default: begin
        r.sel = m.nxt; r.q = quantum - 1; r.ph = 0;
        if (m.cnt < cmax) r.cnt = m.cnt + 1;
      end
    endcase
    return r;
  endfunction

  task automatic cmp(input string nm, input int n, input mdl_t m,
                     input logic [31:0] sel, input logic [31:0] grant,
                     input logic [31:0] busy, input logic [31:0] sw,
                     input logic [31:0] st, input logic [31:0] cnt);
    logic [31:0] eg, eb, all;
    all = (32'd1 << n) - 32'd1;
    eg  = (m.ph == 2) ? 32'd0 : (32'd1 << m.sel);
    eb  = (all & ~eg) | (sb ? eg : 32'd0);
    vectors++;
    if (sel !== 32'(m.sel) || grant !== eg || busy !== eb ||
        sw !== 32'(m.ph == 2) || st !== 32'(m.ph) || cnt !== 32'(m.cnt)) begin
      miscompares++;
      $display("FAIL %s t=%0t got sel=%0d grant=%b busy=%b sw=%0d st=%0d cnt=%0d exp sel=%0d grant=%b busy=%b sw=%0d st=%0d cnt=%0d",
               nm, $time, sel, grant[2:0], busy[2:0], sw, st, cnt,
               m.sel, eg[2:0], eb[2:0], (m.ph == 2), m.ph, m.cnt);
    end
  endtask

  task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL pin_%s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Check the current cycle, then clock both DUTs and the model once.
  task automatic tick();
    #1;
    if (chk_en) begin
      cmp("u2", 2, m2, 32'(sel2), 32'(grant2), 32'(cbusy2), 32'(sw2), 32'(st2), 32'(cnt2));
      cmp("u3", 3, m3, 32'(sel3), 32'(grant3), 32'(cbusy3), 32'(sw3), 32'(st3), 32'(cnt3));
    end
    @(posedge CLK);
    m2 = mstep(m2, 2, Q, 65535, RST, 32'(act2), 32'(safe2), hold);
    m3 = mstep(m3, 3, Q, 7, RST, 32'(act3), 32'(safe3), hold);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; hold = 1'b0; sb = 1'b0;
    act2 = '0; safe2 = '0; act3 = '0; safe3 = '0;
    m2 = '{0, Q - 1, 0, 0, 0};
    m3 = '{0, Q - 1, 0, 0, 0};
    tick();
    chk_en = 1'b1;

    // Both active, always safe: switch at cycle 5, new owner at cycle 6.
    // 3-hart instance with hart1 idle: 0 -> 2 -> 0.
    do_reset();
    act2 = 2'b11; safe2 = 2'b11; act3 = 3'b101; safe3 = 3'b111;
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) begin
        pin("rst_sel", 32'(sel2), 32'd0);
        pin("rst_grant", 32'(grant2), 32'd1);
        pin("rst_busy", 32'(cbusy2), 32'd2);
        pin("rst_cnt", 32'(cnt2), 32'd0);
      end
      if (c == 5) begin
        pin("sw_at5", 32'(sw2), 32'd1);
        pin("busy_sw", 32'(cbusy2), 32'd3);
      end
      if (c == 6) begin
        pin("sel_at6", 32'(sel2), 32'd1);
        pin("cnt_at6", 32'(cnt2), 32'd1);
        pin("n3_first", 32'(sel3), 32'd2);
      end
      if (c == 12) pin("n3_second", 32'(sel3), 32'd0);
      tick();
    end

    // Only hart0 active: never switches.
    do_reset();
    act2 = 2'b01; act3 = 3'b001;
    for (int c = 0; c < 100; c++) tick();
    pin("solo_sel", 32'(sel2), 32'd0);
    pin("solo_state", 32'(st2), 32'd0);
    pin("solo_cnt", 32'(cnt2), 32'd0);
    pin("solo_busy1", 32'(cbusy2[1]), 32'd1);

    // Quantum expired but owner not safe: wait, busy[0] tracks shared busy.
    do_reset();
    act2 = 2'b11; safe2 = 2'b00; act3 = 3'b111; safe3 = 3'b000;
    for (int c = 0; c < 14; c++) begin
      sb = 1'($urandom);
      tick();
    end
    pin("wait_state", 32'(st2), 32'd1);
    safe2 = 2'b01;
    tick();
    pin("wait_then_sw", 32'(sw2), 32'd1);
    sb = 1'b0;

    // Owner deactivates mid-slice: preempted without waiting for q=0.
    do_reset();
    act2 = 2'b11; safe2 = 2'b11;
    tick();
    act2 = 2'b10;
    tick();
    pin("preempt_wait", 32'(st2), 32'd1);
    tick();
    pin("preempt_sw", 32'(sw2), 32'd1);
    tick();
    pin("preempt_sel", 32'(sel2), 32'd1);

    // Hold blocks SWITCH entry; release switches next cycle.
    do_reset();
    act2 = 2'b11; safe2 = 2'b11; hold = 1'b1;
    for (int c = 0; c <= 8; c++) tick();
    pin("hold_state", 32'(st2), 32'd1);
    pin("hold_nosw", 32'(sw2), 32'd0);
    hold = 1'b0;
    tick();
    pin("hold_rel_sw", 32'(sw2), 32'd1);

    // Reset during SWITCH.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    pin("rstsw_sel", 32'(sel2), 32'd0);
    pin("rstsw_cnt", 32'(cnt2), 32'd0);
    pin("rstsw_state", 32'(st2), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) act2 = 2'($urandom);
      if ($urandom_range(7) == 0) act3 = 3'($urandom);
      safe2 = 2'($urandom);
      safe3 = 3'($urandom);
      hold  = ($urandom_range(5) == 0);
      sb    = 1'($urandom);
      RST   = ($urandom_range(199) == 0);
      tick();
    end

    // Saturation of the 3-bit counter.
    hold = 1'b0;
    do_reset();
    act3 = 3'b111; safe3 = 3'b111;
    for (int c = 0; c < 80; c++) tick();
    pin("sat_cnt", 32'(cnt3), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hart_slice_arbiter.md
Name: hart_slice_arbiter

Overview:
- Parametrised successor to the single-rotation hart selector in the RV cluster.
- Time-multiplexes one shared MMU/interconnect port among N_HARTS cores using round-robin time slices of QUANTUM cycles.
- Idle harts are skipped, and a switch happens only at a hart-reported safe point.
- A one-cycle drain state separates owners so the shared port never sees a mixed-hart request; the cluster muxes its per-hart buses with hart_sel.

Parameters:
N_HARTS, 2, number of cores sharing the port (1 allowed: never switches)
QUANTUM, 64, minimum ownership cycles before a voluntary switch (>=1)
CNT_W, 16, width of the saturating switch counter
SEL_W, $clog2(N_HARTS)>0 ? $clog2(N_HARTS) : 1, width of the hart index

Ports:
CLK  in  1  clock
RST  in  1  reset; one clock, synchronous, active-high
w_active  in  N_HARTS  hart g is runnable (not WFI/halted)
w_safe  in  N_HARTS  hart g is at a switchable point: idle next-state, tkn, no exception, no CSR/TLB flush
w_hold  in  1  global inhibit (memory-controller mode, pending pagefault); blocks SWITCH entry
w_shared_busy  in  1  interconnect busy OR TLB busy
w_hart_sel  out  SEL_W  current owner index (registered)
w_grant  out  N_HARTS  one-hot of w_hart_sel; all-zero during SWITCH
w_core_busy  out  N_HARTS  per-hart stall
w_switch  out  1  high for exactly the SWITCH cycle
w_state  out  2  0=OWN 1=WAIT_SAFE 2=SWITCH
w_switch_count  out  CNT_W  completed switches, saturating at all-ones

Behaviour:
- Reset values:
  - state OWN, hart_sel 0, grant = 1 (bit 0), switch 0, switch_count 0.
  - Quantum counter q = QUANTUM-1.
  - core_busy: bit 0 = w_shared_busy, all other bits 1.
- Candidate:
  - Combinational search from hart_sel+1 upward, wrapping modulo N_HARTS, excluding hart_sel.
  - Picks the first g with w_active[g].
  - has_cand=0 if none is found; always 0 when N_HARTS=1.
- OWN:
  - q decrements each cycle while q>0.
  - Transition to WAIT_SAFE when has_cand AND (q==0 OR !w_active[hart_sel]). An inactive owner is preempted without waiting out the quantum.
  - If q==0 and !has_cand, stay in OWN with q held at 0; re-evaluate every cycle.
- WAIT_SAFE:
  - If !has_cand, go to OWN; q stays 0.
  - Else if w_safe[hart_sel] && !w_hold, latch r_next = candidate and go to SWITCH.
  - Else stay.
  - Owner keeps running in this state; q is not reloaded.
- SWITCH (exactly 1 cycle):
  - w_switch=1, grant=0, every core_busy bit = 1.
  - Next edge: hart_sel <= r_next, q <= QUANTUM-1, state <= OWN, switch_count += 1 (saturating).
- w_core_busy[g]:
  - (state!=SWITCH && g==hart_sel) ? w_shared_busy : 1.
  - Combinational from registers plus w_shared_busy, so an owner stall reaches the core the same cycle.
- Latency, safe to new owner:
  - Safe point seen in cycle t → SWITCH in t+1 → new owner unstalled in t+2.
- Simultaneous events:
  - w_hold asserted in the same cycle as w_safe: no transition.
  - w_hold does not affect q.
  - Candidate deactivating in the same cycle WAIT_SAFE→SWITCH is decided: the switch proceeds. The new owner is then preempted through the inactive-owner rule.
- RST asserted mid-SWITCH or mid-WAIT_SAFE: all state returns to reset values on that edge; no partial update of hart_sel.
- N_HARTS not a power of two: the index wraps at N_HARTS-1 → 0; hart_sel is never out of range.

Test Plan:
- Reset, N_HARTS=2, QUANTUM=4, both active, w_safe=11 → SWITCH in cycle 5 after reset release; hart_sel=1 in cycle 6; count=1; busy=11 during SWITCH.
- Only hart0 active, run 100 cycles → hart_sel stays 0, state OWN, count 0, busy[1]=1 throughout.
- Quantum expired, w_safe[0]=0 for 10 cycles, then 1 → stays WAIT_SAFE for 10 cycles; SWITCH on the cycle after safe rises; w_core_busy[0] follows w_shared_busy while waiting.
- N_HARTS=3, hart1 inactive, hart0 owner, quantum expires → next owner is 2, then 0 (1 skipped).
- Owner deactivates at q=30 with another hart active → WAIT_SAFE next cycle, switch without waiting for q=0.
- w_hold=1 with w_safe=1 → no SWITCH; hold released → SWITCH next cycle.
- RST pulsed during SWITCH → hart_sel 0, count unchanged from 0 after reset, state OWN.
- Force count to all-ones → further switches keep it saturated at all-ones.
